// File: rtl/soc_io_controller.sv
// Board I/O responder on the SoC data bus: LED/RGB outputs, debounced buttons and
// switches, sticky button-edge flags with a level interrupt.
module soc_io_controller #(
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  resn,
   input  logic                  bus_req,
   input  logic                  bus_wr,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic [31:0]           bus_wdata,
   input  logic [3:0]            bus_wmask,
   output logic                  bus_ready,
   output logic [31:0]           bus_rdata,
   output logic [3:0]            leds,
   output logic [2:0]            led_rgb0,
   output logic [2:0]            led_rgb1,
   input  logic [3:0]            buttons,
   input  logic [3:0]            switches,
   output logic                  irq
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam int unsigned WordW = ADDR_WIDTH - 2;

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e                state_q, state_d;
   logic [3:0]            leds_q, leds_d;
   logic [2:0]            rgb0_q, rgb0_d;
   logic [2:0]            rgb1_q, rgb1_d;
   logic [3:0]            irq_en_q, irq_en_d;
   logic [3:0]            btn_edge_q, btn_edge_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [7:0]            sync1_q, sync2_q;
   logic [7:0]            deb_q, deb_d;
   logic [7:0][CntW-1:0]  cnt_q, cnt_d;

   logic [WordW-1:0]      addr_word;
   logic                  accept, we;
   logic [31:0]           rd_value;
   logic [3:0]            edge_clr;
   logic [3:0]            btn_rise;
   logic                  unused_bits;

   // Low address bits and unused write-data/mask bits are deliberately ignored.
   assign unused_bits = ^{bus_wdata, bus_wmask, bus_addr[1:0]};
   assign addr_word   = bus_addr[ADDR_WIDTH-1:2];

   // Debounce: a bit flips only after the synchronised value has disagreed with the
   // accepted value for DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 8; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   assign btn_rise = deb_d[3:0] & ~deb_q[3:0];

   always_comb begin
      rd_value = '0;
      case (addr_word)
         WordW'(0): rd_value = {28'd0, leds_q};
         WordW'(1): rd_value = {25'd0, rgb1_q, 1'b0, rgb0_q};
         WordW'(2): rd_value = {24'd0, deb_q};
         WordW'(3): rd_value = {28'd0, btn_edge_q};
         WordW'(4): rd_value = {28'd0, irq_en_q};
         default:   rd_value = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      leds_d   = leds_q;
      rgb0_d   = rgb0_q;
      rgb1_d   = rgb1_q;
      irq_en_d = irq_en_q;
      rdata_d  = '0;
      edge_clr = '0;
      accept   = (state_q == StIdle) && bus_req;
      we       = accept && bus_wr && bus_wmask[0];

      unique case (state_q)
         StIdle: if (bus_req) state_d = StAck;
         StAck:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (accept && !bus_wr) rdata_d = rd_value;

      if (we) begin
         case (addr_word)
            WordW'(0): leds_d = bus_wdata[3:0];
            WordW'(1): begin
               rgb0_d = bus_wdata[2:0];
               rgb1_d = bus_wdata[6:4];
            end
            WordW'(3): edge_clr = bus_wdata[3:0];
            WordW'(4): irq_en_d = bus_wdata[3:0];
            default: ;
         endcase
      end

      // A new edge in the same cycle as its W1C clear must survive.
      btn_edge_d = (btn_edge_q & ~edge_clr) | btn_rise;
   end

   always_ff @(posedge clk or negedge resn) begin
      if (!resn) begin
         state_q    <= StIdle;
         leds_q     <= '0;
         rgb0_q     <= '0;
         rgb1_q     <= '0;
         irq_en_q   <= '0;
         btn_edge_q <= '0;
         rdata_q    <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         leds_q     <= leds_d;
         rgb0_q     <= rgb0_d;
         rgb1_q     <= rgb1_d;
         irq_en_q   <= irq_en_d;
         btn_edge_q <= btn_edge_d;
         rdata_q    <= rdata_d;
         sync1_q    <= {switches, buttons};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus_ready = (state_q == StAck);
   assign bus_rdata = bus_ready ? rdata_q : '0;
   assign leds      = leds_q;
   assign led_rgb0  = rgb0_q;
   assign led_rgb1  = rgb1_q;
   assign irq       = |(btn_edge_q & irq_en_q);

endmodule

// File: tb/tb_soc_io_controller.sv
// Bench for soc_io_controller: directed register/debounce/irq scenarios plus random
// traffic, all checked every cycle against a behavioural model of the register map.
module tb_soc_io_controller;

   localparam int unsigned AW  = 8;
   localparam int unsigned DEB = 4;

   logic          clk;
   logic          resn;
   logic          bus_req;
   logic          bus_wr;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic [3:0]    bus_wmask;
   logic          bus_ready;
   logic [31:0]   bus_rdata;
   logic [3:0]    leds;
   logic [2:0]    led_rgb0;
   logic [2:0]    led_rgb1;
   logic [3:0]    buttons;
   logic [3:0]    switches;
   logic          irq;

   int unsigned n_cmp;
   int unsigned n_err;

   soc_io_controller #(
      .ADDR_WIDTH      (AW),
      .DEBOUNCE_CYCLES (DEB)
   ) u_dut (
      .clk       (clk),
      .resn      (resn),
      .bus_req   (bus_req),
      .bus_wr    (bus_wr),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wmask (bus_wmask),
      .bus_ready (bus_ready),
      .bus_rdata (bus_rdata),
      .leds      (leds),
      .led_rgb0  (led_rgb0),
      .led_rgb1  (led_rgb1),
      .buttons   (buttons),
      .switches  (switches),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [3:0]  m_leds, m_en, m_edge;
   logic [2:0]  m_rgb0, m_rgb1;
   logic [7:0]  m_deb, m_s1, m_s2;
   logic [7:0]  m_hist [DEB];
   logic        m_ack;
   logic [31:0] m_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [AW-1:0] a);
      logic [AW-1:0] w;
      w = {a[AW-1:2], 2'b00};
      case (w)
         8'h00:   return {28'd0, m_leds};
         8'h04:   return {25'd0, m_rgb1, 1'b0, m_rgb0};
         8'h08:   return {24'd0, m_deb};
         8'h0C:   return {28'd0, m_edge};
         8'h10:   return {28'd0, m_en};
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_leds = '0; m_en = '0; m_edge = '0; m_rgb0 = '0; m_rgb1 = '0;
      m_deb = '0; m_s1 = '0; m_s2 = '0; m_ack = 1'b0; m_rd = '0;
      for (int i = 0; i < DEB; i++) m_hist[i] = '0;
   endtask

   // One clock edge of the model, using the inputs that were stable before the edge.
   task automatic m_step();
      logic [3:0]    clr;
      logic [7:0]    nd;
      logic [AW-1:0] w;
      logic          same;
      clr = '0;
      if (!m_ack && bus_req) begin
         m_rd = bus_wr ? 32'd0 : m_read(bus_addr);
         w = {bus_addr[AW-1:2], 2'b00};
         if (bus_wr && bus_wmask[0]) begin
            case (w)
               8'h00: m_leds = bus_wdata[3:0];
               8'h04: begin m_rgb0 = bus_wdata[2:0]; m_rgb1 = bus_wdata[6:4]; end
               8'h0C: clr = bus_wdata[3:0];
               8'h10: m_en = bus_wdata[3:0];
               default: ;
            endcase
         end
         m_ack = 1'b1;
      end else begin
         m_ack = 1'b0;
         m_rd  = '0;
      end
      // Accept a new level once the last DEB synchronised samples all agree on it.
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s2;
      nd = m_deb;
      for (int b = 0; b < 8; b++) begin
         same = 1'b1;
         for (int i = 1; i < DEB; i++) if (m_hist[i][b] != m_hist[0][b]) same = 1'b0;
         if (same) nd[b] = m_hist[0][b];
      end
      m_edge = (m_edge & ~clr) | (nd[3:0] & ~m_deb[3:0]);
      m_deb  = nd;
      m_s2   = m_s1;
      m_s1   = {switches, buttons};
   endtask

   task automatic compare_all();
      check("ready", {31'd0, bus_ready}, {31'd0, m_ack});
      check("rdata", bus_rdata, m_ack ? m_rd : 32'd0);
      check("leds", {28'd0, leds}, {28'd0, m_leds});
      check("rgb0", {29'd0, led_rgb0}, {29'd0, m_rgb0});
      check("rgb1", {29'd0, led_rgb1}, {29'd0, m_rgb1});
      check("irq", {31'd0, irq}, {31'd0, |(m_edge & m_en)});
   endtask

   task automatic step();
      @(posedge clk);
      if (resn) m_step();
      else m_reset();
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] mk, output logic [31:0] rd, output logic rdy);
      bus_req = 1'b1; bus_wr = wr; bus_addr = a; bus_wdata = wd; bus_wmask = mk;
      step();
      rdy = bus_ready;
      rd  = bus_rdata;
      bus_req = 1'b0; bus_wr = 1'b0;
      step();
   endtask

   logic [31:0] rd;
   logic        rdy;
   logic [AW-1:0] addr_pool [7];

   initial begin
      n_cmp = 0; n_err = 0;
      resn = 1'b0; bus_req = 1'b0; bus_wr = 1'b0; bus_addr = '0;
      bus_wdata = '0; bus_wmask = '0; buttons = '0; switches = '0;
      m_reset();
      #1;
      compare_all();
      steps(2);
      resn = 1'b1;
      steps(2);

      // LED register
      xfer(1'b1, 8'h00, 32'hF5, 4'h1, rd, rdy);
      check("wr_leds_ready", {31'd0, rdy}, 32'd1);
      check("wr_leds_val", {28'd0, leds}, 32'h5);
      xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, rdy);
      check("rd_leds", rd, 32'h5);

      // RGB register, masked then unmasked
      xfer(1'b1, 8'h04, 32'h52, 4'h0, rd, rdy);
      check("rgb_masked_ack", {31'd0, rdy}, 32'd1);
      check("rgb_masked", {26'd0, led_rgb1, led_rgb0}, 32'h0);
      xfer(1'b1, 8'h04, 32'h52, 4'h1, rd, rdy);
      check("rgb0_val", {29'd0, led_rgb0}, 32'h2);
      check("rgb1_val", {29'd0, led_rgb1}, 32'h5);

      // Debounce: short glitch dropped, long press accepted
      buttons = 4'h4; steps(2); buttons = 4'h0; steps(10);
      xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, rdy);
      check("glitch_inputs", rd, 32'h0);
      xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, rdy);
      check("glitch_edge", rd, 32'h0);
      buttons = 4'h4; steps(8);
      xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, rdy);
      check("press_inputs", rd, 32'h4);
      xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, rdy);
      check("press_edge", rd, 32'h4);

      // Interrupt enable and W1C
      xfer(1'b1, 8'h10, 32'h4, 4'h1, rd, rdy);
      check("irq_set", {31'd0, irq}, 32'd1);
      xfer(1'b1, 8'h0C, 32'h4, 4'h1, rd, rdy);
      check("irq_clr", {31'd0, irq}, 32'd0);

      // New edge landing on the same edge as its W1C clear
      buttons = 4'h0; steps(10);
      buttons = 4'h4; steps(5);
      xfer(1'b1, 8'h0C, 32'h4, 4'h1, rd, rdy);
      xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, rdy);
      check("set_wins", rd, 32'h4);
      check("set_wins_irq", {31'd0, irq}, 32'd1);

      // Unmapped addresses and read-only INPUTS
      xfer(1'b0, 8'h14, 32'h0, 4'h0, rd, rdy);
      check("unmapped14_rd", rd, 32'h0);
      check("unmapped14_rdy", {31'd0, rdy}, 32'd1);
      xfer(1'b0, 8'h80, 32'h0, 4'h0, rd, rdy);
      check("unmapped80_rd", rd, 32'h0);
      check("unmapped80_rdy", {31'd0, rdy}, 32'd1);
      xfer(1'b1, 8'h08, 32'hFF, 4'h1, rd, rdy);
      xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, rdy);
      check("inputs_ro", rd, 32'h4);

      // Random traffic against the model
      addr_pool = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h0D};
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            {switches, buttons} = 8'($urandom);
            steps($urandom_range(1, 8));
         end else begin
            xfer(1'($urandom), ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                                           : addr_pool[$urandom_range(0, 6)],
                 $urandom, 4'($urandom), rd, rdy);
         end
      end

      // Reset asserted during the ACK cycle
      buttons = 4'h0; switches = 4'h0; steps(10);
      buttons = 4'h1; steps(10);
      xfer(1'b1, 8'h10, 32'hF, 4'h1, rd, rdy);
      xfer(1'b1, 8'h00, 32'hA, 4'h1, rd, rdy);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      bus_req = 1'b1; bus_wr = 1'b1; bus_addr = 8'h00; bus_wdata = 32'h3; bus_wmask = 4'h1;
      step();
      check("pre_rst_ack", {31'd0, bus_ready}, 32'd1);
      resn = 1'b0; bus_req = 1'b0; bus_wr = 1'b0;
      m_reset();
      #1;
      check("rst_ready", {31'd0, bus_ready}, 32'd0);
      check("rst_leds", {28'd0, leds}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      compare_all();
      steps(2);
      resn = 1'b1;
      step();
      xfer(1'b1, 8'h00, 32'h9, 4'h1, rd, rdy);
      check("post_rst_ready", {31'd0, rdy}, 32'd1);
      check("post_rst_leds", {28'd0, leds}, 32'h9);
      steps(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
